instr_fetch_responder: RTL and testbench

Instruction-memory responder for the CPU frontend. It takes the fetch address driven by the program-counter block and returns the opcode/immediate pair stored at that address after a fixed pipeline latency. It contains a loadable program store written through a separate load port. Response backpressure stalls the whole pipeline. It sits between the PC/next-address logic and the program image.

---
 rtl/instr_fetch_responder.sv | 113 +++++++++++
 tb/tb_instr_fetch_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_responder.sv
// Instruction-memory responder: a loadable program store read by PC fetches,
// returning {opcode, imm} through a fixed-latency, backpressure-stallable pipeline.
module instr_fetch_responder #(
   parameter int DEPTH   = 256,
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [23:0]       load_data,
   input  logic              fetch_req,
   input  logic [15:0]       fetch_addr,
   output logic              fetch_ready,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [7:0]        rsp_opcode,
   output logic [15:0]       rsp_imm,
   output logic              rsp_fault,
   output logic [15:0]       fetch_count
);

   localparam logic [23:0] HALT_WORD = 24'hFF_0000;

   logic [23:0] mem_q   [DEPTH];
   logic [23:0] mem_d   [DEPTH];
   logic        vld_q   [LATENCY];
   logic        vld_d   [LATENCY];
   logic [23:0] word_q  [LATENCY];
   logic [23:0] word_d  [LATENCY];
   logic        fault_q [LATENCY];
   logic        fault_d [LATENCY];
   logic [15:0] fetch_count_q;
   logic [15:0] fetch_count_d;

   logic        stall;
   logic        accept;
   logic        out_of_range;
   logic [23:0] rd_word;

   assign stall        = vld_q[LATENCY-1] & ~rsp_ready;
   assign fetch_ready  = ~rst & ~load_en & ~stall;
   assign accept       = fetch_req & fetch_ready;
   // Full 16-bit compare so addresses beyond the store never alias onto it.
   assign out_of_range = (fetch_addr >= 16'(DEPTH));
   assign rd_word      = out_of_range ? HALT_WORD : mem_q[fetch_addr[ADDR_W-1:0]];

   always_comb begin
      mem_d = mem_q;
      if (load_en) begin
         mem_d[load_addr] = load_data;
      end
   end

   always_comb begin
      vld_d         = vld_q;
      word_d        = word_q;
      fault_d       = fault_q;
      fetch_count_d = fetch_count_q;
      if (accept) begin
         fetch_count_d = fetch_count_q + 16'd1;
      end
      // Data only moves with a valid entry, so outputs keep their last word under bubbles.
      if (!stall) begin
         vld_d[0] = accept;
         if (accept) begin
            word_d[0]  = rd_word;
            fault_d[0] = out_of_range;
         end
         for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            if (vld_q[i-1]) begin
               word_d[i]  = word_q[i-1];
               fault_d[i] = fault_q[i-1];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LATENCY; i++) begin
            vld_q[i]   <= 1'b0;
            word_q[i]  <= '0;
            fault_q[i] <= 1'b0;
         end
         fetch_count_q <= '0;
      end else begin
         vld_q         <= vld_d;
         word_q        <= word_d;
         fault_q       <= fault_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   assign rsp_valid   = vld_q[LATENCY-1];
   assign rsp_opcode  = word_q[LATENCY-1][23:16];
   assign rsp_imm     = word_q[LATENCY-1][15:0];
   assign rsp_fault   = fault_q[LATENCY-1];
   assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Directed bench for instr_fetch_responder (DEPTH=256, LATENCY=2) with hand-computed expectations.
module tb_instr_fetch_responder;

   logic        clk;
   logic        rst;
   logic        load_en;
   logic [7:0]  load_addr;
   logic [23:0] load_data;
   logic        fetch_req;
   logic [15:0] fetch_addr;
   logic        fetch_ready;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [7:0]  rsp_opcode;
   logic [15:0] rsp_imm;
   logic        rsp_fault;
   logic [15:0] fetch_count;

   int n_checks = 0;
   int n_fail   = 0;

   instr_fetch_responder #(.DEPTH(256), .ADDR_W(8), .LATENCY(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .load_en     (load_en),
      .load_addr   (load_addr),
      .load_data   (load_data),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_ready (fetch_ready),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_opcode  (rsp_opcode),
      .rsp_imm     (rsp_imm),
      .rsp_fault   (rsp_fault),
      .fetch_count (fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs are driven and outputs sampled here.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_rsp(input string tag, input logic v, input logic [7:0] op,
                            input logic [15:0] imm, input logic flt);
      check_eq({tag, "_valid"}, 32'(rsp_valid), 32'(v));
      check_eq({tag, "_opcode"}, 32'(rsp_opcode), 32'(op));
      check_eq({tag, "_imm"}, 32'(rsp_imm), 32'(imm));
      check_eq({tag, "_fault"}, 32'(rsp_fault), 32'(flt));
   endtask

   task automatic load_word(input logic [7:0] a, input logic [23:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      #1;
      check_eq("ready_during_load", 32'(fetch_ready), 32'd0);
      step();
      load_en = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      load_en    = 1'b0;
      load_addr  = '0;
      load_data  = '0;
      fetch_req  = 1'b0;
      fetch_addr = '0;
      rsp_ready  = 1'b1;
      #2;
      check_rsp("reset", 1'b0, 8'h00, 16'h0000, 1'b0);
      check_eq("reset_count", 32'(fetch_count), 32'd0);
      check_eq("reset_ready", 32'(fetch_ready), 32'd0);
      step();
      rst = 1'b0;

      load_word(8'd0, 24'h01_0005);
      load_word(8'd1, 24'h02_FFFE);
      load_word(8'd2, 24'hFF_0000);

      // In-order fetch of 0,1,2
      fetch_req = 1'b1; fetch_addr = 16'd0;
      step(); fetch_addr = 16'd1; #1;
      check_eq("inord_lat_valid", 32'(rsp_valid), 32'd0);
      step(); fetch_addr = 16'd2; #1;
      check_rsp("inord_r0", 1'b1, 8'h01, 16'h0005, 1'b0);
      step(); fetch_req = 1'b0; #1;
      check_rsp("inord_r1", 1'b1, 8'h02, 16'hFFFE, 1'b0);
      step();
      check_rsp("inord_r2", 1'b1, 8'hFF, 16'h0000, 1'b0);
      step();
      check_rsp("inord_bubble_hold", 1'b0, 8'hFF, 16'h0000, 1'b0);
      check_eq("inord_count", 32'(fetch_count), 32'd3);

      // Backpressure: stall 3 cycles on first response
      fetch_req = 1'b1; fetch_addr = 16'd0;
      step(); fetch_addr = 16'd1;
      step(); rsp_ready = 1'b0; fetch_addr = 16'd2; #1;
      for (int k = 0; k < 3; k++) begin
         check_eq("stall_ready", 32'(fetch_ready), 32'd0);
         check_rsp("stall_hold", 1'b1, 8'h01, 16'h0005, 1'b0);
         step();
      end
      rsp_ready = 1'b1; #1;
      check_rsp("stall_last", 1'b1, 8'h01, 16'h0005, 1'b0);
      check_eq("release_ready", 32'(fetch_ready), 32'd1);
      step(); fetch_req = 1'b0; #1;
      check_rsp("bp_r1", 1'b1, 8'h02, 16'hFFFE, 1'b0);
      step();
      check_rsp("bp_r2", 1'b1, 8'hFF, 16'h0000, 1'b0);
      step();
      check_eq("bp_drain_valid", 32'(rsp_valid), 32'd0);
      check_eq("bp_count", 32'(fetch_count), 32'd6);

      // Out-of-range, highest in-range, then address 0
      fetch_req = 1'b1; fetch_addr = 16'h0100;
      step(); fetch_addr = 16'h00FF;
      step(); fetch_addr = 16'h0000; #1;
      check_rsp("oor", 1'b1, 8'hFF, 16'h0000, 1'b1);
      step(); fetch_req = 1'b0; #1;
      check_rsp("inrange_top", 1'b1, 8'h00, 16'h0000, 1'b0);
      step();
      check_rsp("after_oor", 1'b1, 8'h01, 16'h0005, 1'b0);
      step();
      check_eq("oor_count", 32'(fetch_count), 32'd9);

      // Load/fetch collision, then overwrite while in flight
      fetch_req = 1'b1; fetch_addr = 16'd3;
      load_en = 1'b1; load_addr = 8'd3; load_data = 24'h0A_1234; #1;
      check_eq("collide_ready", 32'(fetch_ready), 32'd0);
      step(); load_en = 1'b0; #1;
      check_eq("collide_next_ready", 32'(fetch_ready), 32'd1);
      check_eq("collide_not_accepted", 32'(fetch_count), 32'd9);
      step(); fetch_req = 1'b0;
      load_en = 1'b1; load_addr = 8'd3; load_data = 24'h0B_5678; #1;
      check_eq("collide_no_early_rsp", 32'(rsp_valid), 32'd0);
      step(); load_en = 1'b0; #1;
      check_rsp("snapshot_old", 1'b1, 8'h0A, 16'h1234, 1'b0);
      step();
      check_eq("snapshot_single", 32'(rsp_valid), 32'd0);
      fetch_req = 1'b1; fetch_addr = 16'd3;
      step(); fetch_req = 1'b0;
      step();
      check_rsp("snapshot_new", 1'b1, 8'h0B, 16'h5678, 1'b0);
      check_eq("snap_count", 32'(fetch_count), 32'd11);

      // Reset with 2 fetches in flight
      fetch_req = 1'b1; fetch_addr = 16'd0;
      step(); fetch_addr = 16'd1;
      step(); fetch_req = 1'b0;
      #2 rst = 1'b1;
      #1;
      check_rsp("midrst", 1'b0, 8'h00, 16'h0000, 1'b0);
      check_eq("midrst_count", 32'(fetch_count), 32'd0);
      check_eq("midrst_ready", 32'(fetch_ready), 32'd0);
      step();
      rst = 1'b0; #1;
      check_eq("postrst_valid0", 32'(rsp_valid), 32'd0);
      step();
      check_eq("postrst_valid1", 32'(rsp_valid), 32'd0);
      fetch_req = 1'b1; fetch_addr = 16'd0;
      step(); fetch_req = 1'b0;
      step();
      check_rsp("postrst_mem0", 1'b1, 8'h00, 16'h0000, 1'b0);
      check_eq("postrst_count", 32'(fetch_count), 32'd1);

      // Counter wrap: 65537 accepts from zero
      rst = 1'b1;
      step();
      rst = 1'b0;
      fetch_req = 1'b1; fetch_addr = 16'd0;
      repeat (65535) step();
      check_eq("count_ffff", 32'(fetch_count), 32'h0000FFFF);
      step();
      check_eq("count_wrap0", 32'(fetch_count), 32'd0);
      step(); fetch_req = 1'b0; #1;
      check_eq("count_wrap1", 32'(fetch_count), 32'd1);
      step();
      check_eq("count_stable", 32'(fetch_count), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
